// File: rtl/iq_nco_pkg.sv
// iq_nco_pkg: shared tags, FSM encoding and phase constants for the IQ NCO scheduler
package iq_nco_pkg;
   typedef logic [1:0] tag_t;
   localparam tag_t TAG_NONE = 2'd0;
   localparam tag_t TAG_SIN  = 2'd1;
   localparam tag_t TAG_COS  = 2'd2;
   typedef enum logic [1:0] {IDLE, SIN, COS} state_t;
   function automatic int quarter(input int pw);
      return 1 << (pw - 2);
   endfunction
   localparam int QUARTER = quarter(12);
endpackage

// File: rtl/iq_nco_scheduler_if.sv
// iq_nco_scheduler_if: sample strobe, frequency handshake, lookup port and I/Q output bundle
interface iq_nco_scheduler_if #(
   parameter int OW = 16,
   parameter int PW = 12,
   parameter int AW = 32
);
   logic                 i_ce;
   logic                 i_freq_valid;
   logic [AW-1:0]        i_freq_word;
   logic                 o_freq_ready;
   logic [PW-1:0]        i_phase_offset;
   logic                 o_lut_ce;
   logic [PW-1:0]        o_lut_phase;
   logic signed [OW:0]   i_lut_val;
   logic signed [OW:0]   o_i;
   logic signed [OW:0]   o_q;
   logic                 o_valid;
   logic                 o_overrun;
   modport master (
      output i_ce, i_freq_valid, i_freq_word, i_phase_offset, i_lut_val,
      input  o_freq_ready, o_lut_ce, o_lut_phase, o_i, o_q, o_valid, o_overrun
   );
   modport slave (
      input  i_ce, i_freq_valid, i_freq_word, i_phase_offset, i_lut_val,
      output o_freq_ready, o_lut_ce, o_lut_phase, o_i, o_q, o_valid, o_overrun
   );
endinterface

// File: rtl/nco_phase_accumulator.sv
// nco_phase_accumulator: phase accumulator with a one-deep pending frequency word
module nco_phase_accumulator #(
   parameter int PW = 12,
   parameter int AW = 32
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_step,
   input  logic          i_freq_valid,
   input  logic [AW-1:0] i_freq_word,
   output logic          o_freq_ready,
   output logic [PW-1:0] o_phase
);
   logic [AW-1:0] acc_q, acc_d, freq_q, freq_d, pend_q, pend_d;
   logic          full_q, full_d, accept;
   // The pending word only lands in freq after this step's acc update, so it affects the next sample
   always_comb begin
      accept = i_freq_valid && !full_q;
      acc_d  = i_step ? acc_q + freq_q : acc_q;
      freq_d = (i_step && full_q) ? pend_q : freq_q;
      pend_d = accept ? i_freq_word : pend_q;
      full_d = accept || (full_q && !i_step);
   end
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         acc_q  <= '0;
         freq_q <= '0;
         pend_q <= '0;
         full_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         freq_q <= freq_d;
         pend_q <= pend_d;
         full_q <= full_d;
      end
   end
   assign o_freq_ready = !full_q;
   assign o_phase      = acc_q[AW-1 -: PW];
endmodule

// File: rtl/iq_nco_scheduler.sv
// iq_nco_scheduler: time-shares one sine lookup between Q (sin) and I (cos) slots per sample strobe,
// realigning results through a tag line matched to the lookup latency
module iq_nco_scheduler
   import iq_nco_pkg::*;
#(
   parameter int OW  = 16,
   parameter int PW  = 12,
   parameter int AW  = 32,
   parameter int LAT = 4
) (
   input logic              i_clk,
   input logic              i_reset,
   iq_nco_scheduler_if.slave bus
);
   localparam logic [PW-1:0] QTR = PW'(quarter(PW));
   state_t                 state_q, state_d;
   logic                   start, valid_q, valid_d, overrun_q, overrun_d, lut_ce_q;
   logic [PW-1:0]          acc_phase, lut_phase_q, lut_phase_d;
   tag_t                   cur_tag, tag_out;
   logic [LAT-1:0][1:0]    tag_q, tag_d;
   logic signed [OW:0]     sin_q, sin_d, i_smp_q, i_smp_d, q_smp_q, q_smp_d;
   nco_phase_accumulator #(.PW(PW), .AW(AW)) u_acc (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_step       (start),
      .i_freq_valid (bus.i_freq_valid),
      .i_freq_word  (bus.i_freq_word),
      .o_freq_ready (bus.o_freq_ready),
      .o_phase      (acc_phase)
   );
   // A strobe during SIN would collide with the pending cos slot, so it is dropped and flagged
   always_comb begin
      start       = bus.i_ce && (state_q != SIN);
      state_d     = start ? SIN : (state_q == SIN) ? COS : IDLE;
      cur_tag     = (state_q == SIN) ? TAG_SIN : (state_q == COS) ? TAG_COS : TAG_NONE;
      lut_phase_d = start ? acc_phase + bus.i_phase_offset :
                    (state_q == SIN) ? lut_phase_q + QTR : lut_phase_q;
      tag_d       = {tag_q[LAT-2:0], cur_tag};
      tag_out     = tag_q[LAT-1];
      sin_d       = (tag_out == TAG_SIN) ? bus.i_lut_val : sin_q;
      valid_d     = (tag_out == TAG_COS);
      i_smp_d     = valid_d ? bus.i_lut_val : i_smp_q;
      q_smp_d     = valid_d ? sin_q : q_smp_q;
      overrun_d   = overrun_q || (bus.i_ce && (state_q == SIN));
   end
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= IDLE;
         lut_phase_q <= '0;
         tag_q       <= '0;
         sin_q       <= '0;
         i_smp_q     <= '0;
         q_smp_q     <= '0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
         lut_ce_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         lut_phase_q <= lut_phase_d;
         tag_q       <= tag_d;
         sin_q       <= sin_d;
         i_smp_q     <= i_smp_d;
         q_smp_q     <= q_smp_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
         lut_ce_q    <= 1'b1;
      end
   end
   assign bus.o_lut_ce    = lut_ce_q;
   assign bus.o_lut_phase = lut_phase_q;
   assign bus.o_i         = i_smp_q;
   assign bus.o_q         = q_smp_q;
   assign bus.o_valid     = valid_q;
   assign bus.o_overrun   = overrun_q;
endmodule

// File: tb/tb_iq_nco_scheduler.sv
// tb_iq_nco_scheduler: directed vector bench with a latency-4 quarter-wave lookup model
module tb_iq_nco_scheduler;
   localparam int OW = 16, PW = 12, AW = 32, LAT = 4;
   typedef struct {int cyc; logic [PW-1:0] p;} ph_t;
   typedef struct {int cyc; logic signed [OW:0] i; logic signed [OW:0] q;} iq_t;
   typedef struct {int gap; bit exp; logic [PW-1:0] p;} vec_t;
   logic clk = 0, rst = 1;
   int cyc = 0, n_chk = 0, n_fail = 0;
   ph_t phq[$];
   iq_t iqq[$];
   vec_t vq[$];
   logic signed [OW:0] pipe [LAT];
   always #5 clk = ~clk;
   iq_nco_scheduler_if #(.OW(OW), .PW(PW), .AW(AW)) bus();
   iq_nco_scheduler #(.OW(OW), .PW(PW), .AW(AW), .LAT(LAT)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );
   // Stand-in table T[k] = 16k+8, folded over four quadrants
   function automatic logic signed [OW:0] lut_fn(input logic [PW-1:0] p);
      logic [PW-3:0] idx;
      logic signed [OW:0] m;
      idx = p[PW-2] ? ~p[PW-3:0] : p[PW-3:0];
      m = $signed({3'b000, idx, 4'b1000});
      return p[PW-1] ? -m : m;
   endfunction
   always @(posedge clk) begin
      cyc <= cyc + 1;
      pipe[0] <= lut_fn(bus.o_lut_phase);
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign bus.i_lut_val = pipe[LAT-1];
   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   always @(negedge clk) if (!rst) begin
      if (phq.size() > 0 && phq[0].cyc == cyc) begin
         check("lut_phase", int'(bus.o_lut_phase), int'(phq[0].p));
         phq.delete(0);
      end
      while (iqq.size() > 0 && iqq[0].cyc < cyc) begin
         check("valid_missing", 0, 1);
         iqq.delete(0);
      end
      if (bus.o_valid) begin
         if (iqq.size() == 0) check("valid_unexpected", 1, 0);
         else begin
            check("valid_cycle", cyc, iqq[0].cyc);
            check("o_i", int'(bus.o_i), int'(iqq[0].i));
            check("o_q", int'(bus.o_q), int'(iqq[0].q));
            iqq.delete(0);
         end
      end
   end
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic do_reset();
      rst = 1;
      bus.i_ce = 0;
      bus.i_freq_valid = 0;
      phq.delete();
      iqq.delete();
      tick(2);
      check("rst_o_i", int'(bus.o_i), 0);
      check("rst_o_q", int'(bus.o_q), 0);
      check("rst_o_valid", int'(bus.o_valid), 0);
      check("rst_o_overrun", int'(bus.o_overrun), 0);
      check("rst_o_lut_phase", int'(bus.o_lut_phase), 0);
      check("rst_o_lut_ce", int'(bus.o_lut_ce), 0);
      check("rst_o_freq_ready", int'(bus.o_freq_ready), 1);
      rst = 0;
      tick(1);
      check("lut_ce_after_rst", int'(bus.o_lut_ce), 1);
   endtask
   task automatic ce_pulse(input bit exp, input logic [PW-1:0] p);
      logic [PW-1:0] pc;
      pc = p + 12'd1024;
      bus.i_ce = 1;
      if (exp) begin
         phq.push_back('{cyc + 1, p});
         phq.push_back('{cyc + 2, pc});
         iqq.push_back('{cyc + 7, lut_fn(pc), lut_fn(p)});
      end
      tick(1);
      bus.i_ce = 0;
   endtask
   task automatic run_vecs();
      while (vq.size() > 0) begin
         ce_pulse(vq[0].exp, vq[0].p);
         tick(vq[0].gap - 1);
         vq.delete(0);
      end
   endtask
   task automatic load(input logic [AW-1:0] w);
      bus.i_freq_word = w;
      bus.i_freq_valid = 1;
      tick(1);
      bus.i_freq_valid = 0;
      check("ready_after_load", int'(bus.o_freq_ready), 0);
   endtask
   task automatic drain();
      tick(10);
      check("phase_queue_empty", phq.size(), 0);
      check("iq_queue_empty", iqq.size(), 0);
   endtask
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
   initial begin
      bus.i_ce = 0;
      bus.i_freq_valid = 0;
      bus.i_freq_word = '0;
      bus.i_phase_offset = '0;
      do_reset();
      // quarter-turn steps, first strobe still uses the old (zero) increment
      load(32'h4000_0000);
      ce_pulse(1, 12'd0);
      check("ready_return", int'(bus.o_freq_ready), 1);
      tick(3);
      vq.push_back('{4, 1'b1, 12'd0});
      vq.push_back('{4, 1'b1, 12'd1024});
      vq.push_back('{4, 1'b1, 12'd2048});
      vq.push_back('{4, 1'b1, 12'd3072});
      vq.push_back('{4, 1'b1, 12'd0});
      run_vecs();
      drain();
      // strobes every two clocks
      do_reset();
      load(32'h0100_0000);
      vq.push_back('{2, 1'b1, 12'd0});
      vq.push_back('{2, 1'b1, 12'd0});
      vq.push_back('{2, 1'b1, 12'd16});
      vq.push_back('{2, 1'b1, 12'd32});
      vq.push_back('{2, 1'b1, 12'd48});
      vq.push_back('{2, 1'b1, 12'd64});
      run_vecs();
      drain();
      check("no_overrun", int'(bus.o_overrun), 0);
      // back-to-back strobe is dropped and leaves acc untouched
      do_reset();
      load(32'h4000_0000);
      vq.push_back('{4, 1'b1, 12'd0});
      vq.push_back('{1, 1'b1, 12'd0});
      vq.push_back('{4, 1'b0, 12'd0});
      vq.push_back('{4, 1'b1, 12'd1024});
      run_vecs();
      check("overrun_set", int'(bus.o_overrun), 1);
      drain();
      check("overrun_sticky", int'(bus.o_overrun), 1);
      // word offered together with a strobe, second word waits for ready
      do_reset();
      bus.i_freq_word = 32'h0100_0000;
      bus.i_freq_valid = 1;
      ce_pulse(1, 12'd0);
      check("ready_low_same_cycle", int'(bus.o_freq_ready), 0);
      bus.i_freq_word = 32'h0200_0000;
      tick(2);
      check("ready_held_low", int'(bus.o_freq_ready), 0);
      ce_pulse(1, 12'd0);
      check("ready_after_apply", int'(bus.o_freq_ready), 1);
      tick(1);
      bus.i_freq_valid = 0;
      check("second_word_taken", int'(bus.o_freq_ready), 0);
      tick(2);
      ce_pulse(1, 12'd0);
      check("ready_after_second_apply", int'(bus.o_freq_ready), 1);
      tick(3);
      ce_pulse(1, 12'd16);
      tick(3);
      ce_pulse(1, 12'd48);
      drain();
      // reset with two samples in flight
      do_reset();
      load(32'h4000_0000);
      ce_pulse(1, 12'd0);
      tick(1);
      ce_pulse(1, 12'd0);
      tick(2);
      do_reset();
      tick(10);
      check("flush_outputs_i", int'(bus.o_i), 0);
      check("flush_outputs_q", int'(bus.o_q), 0);
      ce_pulse(1, 12'd0);
      tick(3);
      ce_pulse(1, 12'd0);
      drain();
      // static phase offset with zero increment
      do_reset();
      bus.i_phase_offset = 12'd1024;
      vq.push_back('{4, 1'b1, 12'd1024});
      vq.push_back('{4, 1'b1, 12'd1024});
      vq.push_back('{4, 1'b1, 12'd1024});
      run_vecs();
      drain();
      bus.i_phase_offset = '0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
